// File: rtl/codec_config_pkg.sv
// Shared types for the codec configuration sequencer.
//   state_t     : sequencer FSM states
//   cfg_entry_t : one table entry {addr, data, poll}
//   cfg_table_t : full-depth table, indexed by an 8-bit entry index
//   DEFAULT_TABLE : WM8731 bring-up writes sent through the AV Config data register
package codec_config_pkg;

    localparam int TABLE_DEPTH          = 256;
    localparam int DEFAULT_NUM_ENTRIES  = 11;
    localparam logic [1:0] AV_DATA_ADDR = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        POLL,
        GAP,
        NEXT,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [1:0]  addr;
        logic [31:0] data;
        logic        poll;
    } cfg_entry_t;

    typedef cfg_entry_t [TABLE_DEPTH-1:0] cfg_table_t;

    // Codec register writes are 7-bit register number + 9-bit value.
    function automatic cfg_entry_t wm8731_write(input logic [6:0] reg_addr, input logic [8:0] value);
        cfg_entry_t e;
        e.addr = AV_DATA_ADDR;
        e.data = {16'h0000, reg_addr, value};
        e.poll = 1'b1;
        return e;
    endfunction

    function automatic cfg_table_t build_default_table();
        cfg_table_t t;
        t     = '0;
        t[0]  = wm8731_write(7'd15, 9'h000); // reset
        t[1]  = wm8731_write(7'd0,  9'h017); // left line in
        t[2]  = wm8731_write(7'd1,  9'h017); // right line in
        t[3]  = wm8731_write(7'd2,  9'h079); // left headphone
        t[4]  = wm8731_write(7'd3,  9'h079); // right headphone
        t[5]  = wm8731_write(7'd4,  9'h012); // analog path
        t[6]  = wm8731_write(7'd5,  9'h000); // digital path
        t[7]  = wm8731_write(7'd6,  9'h000); // power down control
        t[8]  = wm8731_write(7'd7,  9'h042); // digital interface format
        t[9]  = wm8731_write(7'd8,  9'h000); // sampling control
        t[10] = wm8731_write(7'd9,  9'h001); // activate
        return t;
    endfunction

    localparam cfg_table_t DEFAULT_TABLE = build_default_table();

endpackage

// File: rtl/codec_config_sequencer_if.sv
// Avalon-MM bus between the sequencer (master) and the AV Config slave.
//   address/byteenable/read/write/writedata : master -> slave
//   readdata/waitrequest                    : slave -> master
interface codec_config_sequencer_if;

    logic [1:0]  av_config_slave_address;
    logic [3:0]  av_config_slave_byteenable;
    logic        av_config_slave_read;
    logic        av_config_slave_write;
    logic [31:0] av_config_slave_writedata;
    logic [31:0] av_config_slave_readdata;
    logic        av_config_slave_waitrequest;

    modport master (
        output av_config_slave_address,
        output av_config_slave_byteenable,
        output av_config_slave_read,
        output av_config_slave_write,
        output av_config_slave_writedata,
        input  av_config_slave_readdata,
        input  av_config_slave_waitrequest
    );

    modport slave (
        input  av_config_slave_address,
        input  av_config_slave_byteenable,
        input  av_config_slave_read,
        input  av_config_slave_write,
        input  av_config_slave_writedata,
        output av_config_slave_readdata,
        output av_config_slave_waitrequest
    );

endinterface

// File: rtl/codec_init_rom.sv
// Combinational lookup of the configuration table.
//   i_idx   : entry index
//   o_entry : {addr, data, poll} of that entry
module codec_init_rom
    import codec_config_pkg::*;
#(
    parameter cfg_table_t TABLE = DEFAULT_TABLE
) (
    input  logic [7:0] i_idx,
    output cfg_entry_t o_entry
);

    assign o_entry = TABLE[i_idx];

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the configuration table, writing each entry to the AV Config slave and,
// for flagged entries, polling the status register until the transfer finishes.
//   clk, reset : clock, synchronous active-high reset
//   start      : single-cycle pulse, (re)runs the sequence when not busy
//   busy       : sequence in progress
//   done       : sequence completed (sticky until next run)
//   error      : status poll timed out (sticky until next run)
//   entry_idx  : current / failing table index
//   av         : Avalon-MM master port to the AV Config slave
module codec_config_sequencer
    import codec_config_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = DEFAULT_NUM_ENTRIES,
    parameter logic [1:0]  STATUS_ADDR = 2'd1,
    parameter int unsigned BUSY_BIT    = 0,
    parameter int unsigned POLL_LIMIT  = 1024,
    parameter bit          AUTO_START  = 1'b1,
    parameter cfg_table_t  TABLE       = DEFAULT_TABLE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] entry_idx,
    codec_config_sequencer_if.master av
);

    localparam int unsigned    CNT_W    = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_LIMIT - 1);
    localparam logic [7:0]     LAST_IDX = 8'(NUM_ENTRIES - 1);

    state_t           r_state;
    logic [7:0]       r_idx;
    logic [CNT_W-1:0] r_poll_cnt;
    logic             r_pending;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic             r_read;
    logic             r_write;
    logic [1:0]       r_address;
    logic [3:0]       r_byteenable;
    logic [31:0]      r_writedata;

    logic [7:0]       w_rom_idx;
    cfg_entry_t       w_entry;
    logic             w_unused_status;

    // Only the busy bit of the status word drives the sequence.
    assign w_unused_status = ^av.av_config_slave_readdata;

    // The bus outputs are registered, so the ROM is addressed with the index of the
    // write about to be issued: entry 0 when launching, idx+1 when advancing.
    always_comb begin
        w_rom_idx = r_idx;
        case (r_state)
            NEXT:              w_rom_idx = r_idx + 8'd1;
            IDLE, DONE, ERROR: w_rom_idx = 8'd0;
            default:           w_rom_idx = r_idx;
        endcase
    end

    codec_init_rom #(
        .TABLE(TABLE)
    ) u_rom (
        .i_idx   (w_rom_idx),
        .o_entry (w_entry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_poll_cnt   <= '0;
            r_pending    <= AUTO_START;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_byteenable <= '0;
            r_writedata  <= '0;
        end else begin
            case (r_state)
                IDLE, DONE, ERROR: begin
                    // r_pending can only be set while in IDLE.
                    if (r_pending || start) begin
                        r_state      <= WRITE;
                        r_idx        <= '0;
                        r_pending    <= 1'b0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_busy       <= 1'b1;
                        r_write      <= 1'b1;
                        r_address    <= w_entry.addr;
                        r_byteenable <= 4'hF;
                        r_writedata  <= w_entry.data;
                    end
                end
                WRITE: begin
                    if (!av.av_config_slave_waitrequest) begin
                        r_write     <= 1'b0;
                        r_writedata <= '0;
                        if (w_entry.poll) begin
                            r_state    <= POLL;
                            r_poll_cnt <= '0;
                            r_read     <= 1'b1;
                            r_address  <= STATUS_ADDR;
                        end else begin
                            r_state      <= NEXT;
                            r_address    <= '0;
                            r_byteenable <= '0;
                        end
                    end
                end
                POLL: begin
                    if (!av.av_config_slave_waitrequest) begin
                        r_read       <= 1'b0;
                        r_address    <= '0;
                        r_byteenable <= '0;
                        if (!av.av_config_slave_readdata[BUSY_BIT]) begin
                            r_state <= NEXT;
                        end else if (r_poll_cnt == CNT_LAST) begin
                            r_state <= ERROR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_poll_cnt <= r_poll_cnt + 1'b1;
                            r_state    <= GAP;
                        end
                    end
                end
                GAP: begin
                    r_state      <= POLL;
                    r_read       <= 1'b1;
                    r_address    <= STATUS_ADDR;
                    r_byteenable <= 4'hF;
                end
                NEXT: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx        <= r_idx + 8'd1;
                        r_state      <= WRITE;
                        r_write      <= 1'b1;
                        r_address    <= w_entry.addr;
                        r_byteenable <= 4'hF;
                        r_writedata  <= w_entry.data;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy                           = r_busy;
    assign done                           = r_done;
    assign error                          = r_error;
    assign entry_idx                      = r_idx;
    assign av.av_config_slave_address     = r_address;
    assign av.av_config_slave_byteenable  = r_byteenable;
    assign av.av_config_slave_read        = r_read;
    assign av.av_config_slave_write       = r_write;
    assign av.av_config_slave_writedata   = r_writedata;

endmodule

// File: tb/tb_codec_config_sequencer.sv
`timescale 1ns/1ps
module tb_codec_config_sequencer;
    import codec_config_pkg::*;

    localparam int         NUM     = 11;
    localparam int         LIMIT_A = 8;
    localparam logic [1:0] STAT    = 2'd1;
    localparam int         BBIT    = 0;
    localparam int         BUDGET  = 2000;

    function automatic cfg_table_t make_table(input bit mixed);
        cfg_table_t t;
        t = '0;
        for (int i = 0; i < NUM; i++) begin
            t[i].addr = 2'(i * 3 + (mixed ? 1 : 0));
            t[i].data = (32'h1F3C_0000 + 32'(i) * 32'h0001_0203) ^ (mixed ? 32'hFFFF_0000 : 32'h0);
            t[i].poll = mixed ? ((i % 3) != 1) : 1'b1;
        end
        return t;
    endfunction

    localparam cfg_table_t TBL_A = make_table(1'b0);
    localparam cfg_table_t TBL_B = make_table(1'b1);

    logic       clk = 1'b0;
    logic       reset;
    logic       start_a;
    logic       start_b = 1'b0;
    logic       busy_a, done_a, error_a;
    logic       busy_b, done_b, error_b;
    logic [7:0] idx_a, idx_b;

    codec_config_sequencer_if av_a ();
    codec_config_sequencer_if av_b ();

    always #5 clk = ~clk;

    codec_config_sequencer #(
        .NUM_ENTRIES(NUM), .STATUS_ADDR(STAT), .BUSY_BIT(BBIT),
        .POLL_LIMIT(LIMIT_A), .AUTO_START(1'b1), .TABLE(TBL_A)
    ) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .error(error_a), .entry_idx(idx_a), .av(av_a)
    );

    codec_config_sequencer #(
        .NUM_ENTRIES(NUM), .STATUS_ADDR(STAT), .BUSY_BIT(BBIT),
        .POLL_LIMIT(1024), .AUTO_START(1'b1), .TABLE(TBL_B)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .error(error_b), .entry_idx(idx_b), .av(av_b)
    );

    // Second instance: zero-wait slave, status never busy (other status bits set).
    assign av_b.av_config_slave_waitrequest = 1'b0;
    assign av_b.av_config_slave_readdata    = 32'hFFFF_FFFE;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] txn(input logic is_rd, input logic [1:0] a, input logic [31:0] d);
        return {28'd0, 1'b1, is_rd, a, d};
    endfunction

    // Reference model: expected transaction list and completion cycle from the table rules.
    int            busy_reads [NUM];
    logic [63:0]   exp_q [$];
    int            exp_end;
    bit            exp_err;
    int            exp_err_idx;

    task automatic build_model();
        int cost;
        int n;
        exp_q.delete();
        exp_err     = 0;
        exp_err_idx = 0;
        cost        = 1;
        for (int i = 0; i < NUM; i++) begin
            exp_q.push_back(txn(1'b0, TBL_A[i].addr, TBL_A[i].data));
            if (!TBL_A[i].poll) begin
                cost += 2;
            end else if (busy_reads[i] >= LIMIT_A) begin
                for (int r = 0; r < LIMIT_A; r++) exp_q.push_back(txn(1'b1, STAT, 32'h0));
                cost       += 2 * LIMIT_A;
                exp_err     = 1;
                exp_err_idx = i;
                break;
            end else begin
                n = busy_reads[i] + 1;
                for (int r = 0; r < n; r++) exp_q.push_back(txn(1'b1, STAT, 32'h0));
                cost += 2 * n + 1;
            end
        end
        exp_end = cost;
    endtask

    // Observe and drive the bus at each falling edge; the inputs set here are what the
    // DUT samples at the following rising edge.
    task automatic run_seq(input string tag, input bit rand_wait, input int first_wait,
                           input int start_at, input int abort_write);
        int          stalls, wr_seen, forced, end_cyc, ent;
        int          rd_cnt [NUM];
        bit          fin, prev_wait, prev_acc_wr, prev_acc_rd, wt, acc, strobe;
        logic [39:0] bus, prev_bus;
        logic [31:0] rdv;
        logic [63:0] got;
        build_model();
        foreach (rd_cnt[i]) rd_cnt[i] = 0;
        stalls = 0; wr_seen = 0; forced = 0; end_cyc = 0;
        fin = 0; prev_wait = 0; prev_acc_wr = 0; prev_acc_rd = 0; prev_bus = '0;
        for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
            @(negedge clk);
            start_a = (cyc == start_at);
            strobe  = av_a.av_config_slave_read || av_a.av_config_slave_write;
            bus = {av_a.av_config_slave_read, av_a.av_config_slave_write, av_a.av_config_slave_address,
                   av_a.av_config_slave_byteenable, av_a.av_config_slave_writedata};
            if (cyc == 1) begin
                check_eq($sformatf("%s/first_write", tag), av_a.av_config_slave_write, 1'b1);
                check_eq($sformatf("%s/flags_clear", tag), {done_a, error_a}, 2'b00);
            end
            if (prev_wait)   check_eq($sformatf("%s/hold", tag), bus, prev_bus);
            if (prev_acc_wr) check_eq($sformatf("%s/wr_deassert", tag), av_a.av_config_slave_write, 1'b0);
            if (prev_acc_rd) check_eq($sformatf("%s/rd_deassert", tag), av_a.av_config_slave_read, 1'b0);
            if (strobe) begin
                check_eq($sformatf("%s/rw_excl", tag), av_a.av_config_slave_read && av_a.av_config_slave_write, 1'b0);
                check_eq($sformatf("%s/be", tag), av_a.av_config_slave_byteenable, 4'hF);
            end
            if (abort_write >= 0 && av_a.av_config_slave_write && wr_seen == abort_write) begin
                av_a.av_config_slave_waitrequest = 1'b1;
                reset = 1'b1;
                @(negedge clk);
                check_eq($sformatf("%s/abort_outputs", tag),
                         {busy_a, done_a, error_a, idx_a, av_a.av_config_slave_read, av_a.av_config_slave_write,
                          av_a.av_config_slave_address, av_a.av_config_slave_byteenable,
                          av_a.av_config_slave_writedata}, 64'h0);
                return;
            end
            if (done_a || error_a) begin
                fin     = 1;
                end_cyc = cyc;
            end else begin
                check_eq($sformatf("%s/busy", tag), busy_a, 1'b1);
                if (strobe && av_a.av_config_slave_write && wr_seen == 0 && forced < first_wait) begin
                    wt = 1;
                    forced++;
                end else begin
                    wt = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
                end
                acc = strobe && !wt;
                if (strobe && wt) stalls++;
                ent = wr_seen - 1;
                rdv = $urandom;
                rdv[BBIT] = 1'b0;
                if (av_a.av_config_slave_read && ent >= 0 && ent < NUM)
                    rdv[BBIT] = (rd_cnt[ent] < busy_reads[ent]);
                av_a.av_config_slave_waitrequest = wt;
                av_a.av_config_slave_readdata    = rdv;
                if (acc) begin
                    got = txn(av_a.av_config_slave_read, av_a.av_config_slave_address,
                              av_a.av_config_slave_write ? av_a.av_config_slave_writedata : 32'h0);
                    if (exp_q.size() > 0) check_eq($sformatf("%s/txn", tag), got, exp_q.pop_front());
                    else                  check_eq($sformatf("%s/extra_txn", tag), got, 64'h0);
                    if (av_a.av_config_slave_write) wr_seen++;
                    else if (ent >= 0 && ent < NUM) rd_cnt[ent]++;
                end
                prev_wait   = strobe && wt;
                prev_bus    = bus;
                prev_acc_wr = acc && av_a.av_config_slave_write;
                prev_acc_rd = acc && av_a.av_config_slave_read;
            end
        end
        if (!fin) begin
            check_eq($sformatf("%s/timeout", tag), 1'b1, 1'b0);
            return;
        end
        check_eq($sformatf("%s/end_cycle", tag), end_cyc, exp_end + stalls);
        check_eq($sformatf("%s/done", tag), done_a, !exp_err);
        check_eq($sformatf("%s/error", tag), error_a, exp_err);
        check_eq($sformatf("%s/busy_end", tag), busy_a, 1'b0);
        check_eq($sformatf("%s/missing_txn", tag), exp_q.size(), 0);
        check_eq($sformatf("%s/entry_idx", tag), idx_a, exp_err ? exp_err_idx : NUM - 1);
        av_a.av_config_slave_waitrequest = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq($sformatf("%s/quiet", tag),
                     {av_a.av_config_slave_read, av_a.av_config_slave_write, done_a, error_a},
                     {2'b00, !exp_err, exp_err});
        end
    endtask

    // Second-instance monitor: rising edges counted after reset release, outputs sampled at falling edges.
    int b_edges = 0, b_wr = 0, b_rd = 0, b_end = 0;
    bit b_fin = 0;

    always @(posedge clk) if (!reset && !b_fin) b_edges++;

    always @(negedge clk) begin
        if (b_edges > 0 && !b_fin) begin
            if (av_b.av_config_slave_write) begin
                if (b_wr < NUM)
                    check_eq("b_write", {av_b.av_config_slave_address, av_b.av_config_slave_writedata},
                             {TBL_B[b_wr].addr, TBL_B[b_wr].data});
                else
                    check_eq("b_extra_write", 1'b1, 1'b0);
                b_wr++;
            end
            if (av_b.av_config_slave_read) b_rd++;
            if (done_b) begin
                b_fin = 1;
                b_end = b_edges;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_exp_end, b_exp_rd;
        reset   = 1'b1;
        start_a = 1'b0;
        av_a.av_config_slave_waitrequest = 1'b0;
        av_a.av_config_slave_readdata    = 32'h0;
        foreach (busy_reads[i]) busy_reads[i] = 0;
        repeat (3) @(negedge clk);
        check_eq("reset_state_a",
                 {busy_a, done_a, error_a, idx_a, av_a.av_config_slave_read, av_a.av_config_slave_write,
                  av_a.av_config_slave_address, av_a.av_config_slave_byteenable, av_a.av_config_slave_writedata}, 64'h0);
        check_eq("reset_state_b",
                 {busy_b, done_b, error_b, idx_b, av_b.av_config_slave_read, av_b.av_config_slave_write,
                  av_b.av_config_slave_address, av_b.av_config_slave_byteenable, av_b.av_config_slave_writedata}, 64'h0);
        reset = 1'b0;

        // Auto-start after reset, zero-wait, status idle: 11 x (write, read, next).
        run_seq("auto", 1'b0, 0, 0, -1);

        b_exp_end = 1;
        b_exp_rd  = 0;
        for (int i = 0; i < NUM; i++) begin
            b_exp_end += TBL_B[i].poll ? 3 : 2;
            b_exp_rd  += TBL_B[i].poll ? 1 : 0;
        end
        check_eq("b_done_seen", b_fin, 1'b1);
        check_eq("b_end_cycle", b_end, b_exp_end);
        check_eq("b_writes", b_wr, NUM);
        check_eq("b_reads", b_rd, b_exp_rd);

        // Rerun from DONE: 3 stall cycles on the first write, entry 2 busy for 5 reads.
        busy_reads[2] = 5;
        start_a = 1'b1;
        run_seq("stall_poll", 1'b0, 3, 0, -1);

        // Random waitrequest and random busy counts within the poll limit.
        repeat (2) begin
            foreach (busy_reads[i]) busy_reads[i] = $urandom_range(0, 3);
            start_a = 1'b1;
            run_seq("random", 1'b1, 0, 0, -1);
        end

        // start pulse while busy must not disturb the run.
        foreach (busy_reads[i]) busy_reads[i] = 0;
        start_a = 1'b1;
        run_seq("start_busy", 1'b0, 0, 12, -1);

        // Status stuck busy at entry 2: poll limit reached, error at entry 2.
        busy_reads[2] = 100;
        start_a = 1'b1;
        run_seq("poll_timeout", 1'b0, 0, 0, -1);

        // start from ERROR clears it and reruns from entry 0.
        busy_reads[2] = 0;
        start_a = 1'b1;
        run_seq("restart", 1'b0, 0, 0, -1);

        // Reset while the 4th write is stalled, then auto-restart from entry 0.
        start_a = 1'b1;
        run_seq("abort", 1'b0, 0, 0, 3);
        reset = 1'b0;
        av_a.av_config_slave_waitrequest = 1'b0;
        run_seq("after_reset", 1'b0, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/codec_config_sequencer.md
Name: codec_config_sequencer

Overview:
- Avalon-MM master that initialises the audio codec through the AV Config slave (av_config_slave_* bus) after reset, and again on software request.
- Walks a fixed table of register writes. After each flagged write it polls the AV Config status register until the transfer completes.
- Reports busy/done/error to the software interface so the pitch datapath stays muted until the codec is configured.

Parameters:
- NUM_ENTRIES, 11, number of table entries (1..255)
- STATUS_ADDR, 2'd1, AV Config status register address
- BUSY_BIT, 0, bit of status readdata that is 1 while a config transfer is in flight
- POLL_LIMIT, 1024, maximum status reads per entry before error (>=1)
- AUTO_START, 1, 1 = run the sequence once after reset without a start pulse

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse, (re)run sequence
- busy  out  1  sequence in progress
- done  out  1  sequence completed successfully (sticky)
- error  out  1  poll timeout (sticky)
- entry_idx  out  8  current/failing table index
- av_config_slave_address  out  2  Avalon address
- av_config_slave_byteenable  out  4  Avalon byteenable
- av_config_slave_read  out  1  Avalon read
- av_config_slave_write  out  1  Avalon write
- av_config_slave_writedata  out  32  Avalon writedata
- av_config_slave_readdata  in  32  Avalon readdata, valid when read && !waitrequest
- av_config_slave_waitrequest  in  1  Avalon waitrequest

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: all outputs 0, state IDLE, idx 0, poll counter 0. An auto-start pending flag is set to AUTO_START.
- Table entry fields: addr[1:0], data[31:0], poll (1 bit). The entry is selected combinationally by idx.
- IDLE:
  - Bus idle.
  - If pending flag or start: go to WRITE, set idx=0, clear pending, done and error.
- WRITE:
  - write=1, byteenable=4'hF, address=entry.addr, writedata=entry.data.
  - Hold all of these stable while waitrequest=1.
  - On !waitrequest: go to POLL (clear poll counter) if entry.poll, else go to NEXT.
- POLL:
  - read=1, address=STATUS_ADDR, byteenable=4'hF.
  - Hold while waitrequest=1.
  - On !waitrequest, sample readdata:
    - bit BUSY_BIT == 0: go to NEXT.
    - else if counter == POLL_LIMIT-1: go to ERROR.
    - else increment counter and go to GAP.
- GAP: one idle cycle, then POLL.
- NEXT:
  - If idx == NUM_ENTRIES-1: go to DONE.
  - Else idx++ and go to WRITE.
- DONE: done=1. start → WRITE with idx=0, done cleared.
- ERROR: error=1, entry_idx frozen at the failing entry. start → WRITE with idx=0, error cleared.
- busy=1 in WRITE, POLL, GAP and NEXT. start is ignored while busy.
- read and write are never asserted together. Both deassert in the cycle after acceptance; no back-to-back transactions.
- Zero-wait latency:
  - Flagged entry = 3 cycles (WRITE, POLL, NEXT).
  - Unflagged entry = 2 cycles.
  - First write is issued in the 2nd cycle after reset deasserts.
- Reset mid-transaction, even with waitrequest high: outputs are 0 at the next edge and the transaction is abandoned. With AUTO_START the sequence restarts at idx 0.
- Poll counter is clog2(POLL_LIMIT) bits wide and saturates logically via the compare.

Decomposition:
- Package codec_config_pkg holds:
  - state enum (IDLE, WRITE, POLL, GAP, NEXT, DONE, ERROR)
  - packed struct cfg_entry_t {addr, data, poll}
  - the default NUM_ENTRIES-long constant table of codec register writes
- Sub-module codec_init_rom: input idx, output cfg_entry_t, combinational lookup of the package table. The bench overrides it with a test table.

Test Plan:
- AUTO_START=1, zero-wait slave, status=0, all entries poll=1 → 11 writes (each one cycle, data matches table), each followed by exactly one status read; done=1 and busy=0 at cycle 34 after reset release.
- waitrequest=1 for 3 cycles on entry 0 write → write, address and writedata stable 4 cycles; exactly one write accepted; idx then advances normally.
- Entry 2 status BUSY_BIT=1 for 5 reads, then 0 → 6 reads with one idle cycle between each, then the entry 3 write.
- POLL_LIMIT=8, status stuck busy at entry 2 → exactly 8 reads, error=1, entry_idx=2, no further bus activity. start pulse → error clears and the sequence restarts at idx 0.
- reset asserted during a WRITE with waitrequest=1 → write=0 and busy=0 at the next edge. After release the sequence restarts from idx 0.
- start pulsed while busy → ignored (sequence and table length unchanged). start in DONE → done clears and a full 11-entry rerun follows.
